// File: rtl/asip_fetch_pkg.sv
// Shared types for the ASIP instruction fetch stage: FSM states, default widths
// and the prefetch buffer entry layout.
package asip_fetch_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_INST_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/asip_fetch_unit_fifo.sv
// Prefetch buffer: DEPTH-entry circular FIFO of {pc, inst} entries with a flush
// that empties it in one cycle. DEPTH must be a power of two.
module fetch_fifo
  import asip_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               wdata,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PMASK = PW'(DEPTH - 1);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= (wr_ptr + PW'(1)) & PMASK;
      end
      if (pop) rd_ptr <= (rd_ptr + PW'(1)) & PMASK;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/asip_fetch_unit.sv
// Fetch stage: owns the fetch PC, runs single-outstanding req/ack reads and buffers
// words in fetch_fifo. Define FETCH_PERF_EN to add bubble_cnt/flush_cnt outputs.
module asip_fetch_unit
  import asip_fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              ADDR_W   = DEF_ADDR_W,
  parameter int              INST_W   = DEF_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              inst_ready,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       bubble_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state, state_next;
  logic [ADDR_W-1:0] fetch_pc, drop_addr;
  logic [CW-1:0] count, count_next;
  logic          empty, full, push, pop, room;
  fetch_entry_t  head, wentry;

  assign pop  = !empty && inst_ready && !redirect;
  assign push = (state == REQ) && mem_ack && !redirect;

  always_comb begin
    count_next = count;
    if (redirect)
      count_next = '0;
    else if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);
  end

  assign room = (count_next < CW'(DEPTH));

  assign wentry.pc   = fetch_pc;
  assign wentry.inst = mem_rdata;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wentry),
    .head  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign inst_valid = !empty;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;
  assign mem_req    = (state != IDLE);

  // A redirect while a read is outstanding cannot withdraw the request, so the
  // old address is kept on the bus in DROP until its ack arrives.
  always_comb begin
    state_next = state;
    mem_addr   = '0;
    case (state)
      IDLE: if (room) state_next = REQ;
      REQ: begin
        mem_addr = fetch_pc;
        if (mem_ack) state_next = room ? REQ : IDLE;
      end
      DROP: begin
        mem_addr = drop_addr;
        if (mem_ack) state_next = room ? REQ : IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (redirect) state_next = (state == IDLE || mem_ack) ? REQ : DROP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      drop_addr <= '0;
    end else begin
      state <= state_next;
      if (redirect)
        fetch_pc <= redirect_pc;
      else if (push)
        fetch_pc <= fetch_pc + ADDR_W'(1);
      if (redirect && state != IDLE && !mem_ack)
        drop_addr <= mem_addr;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating counters of starved core cycles and accepted redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (inst_ready && empty && bubble_cnt != 16'hFFFF)
        bubble_cnt <= bubble_cnt + 16'd1;
      if (redirect && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule
